mem_stage: RTL and testbench

Memory-access stage of the 5-stage MIPS-lite pipeline (no-forwarding variant). Holds the EX/MEM pipeline register, drives the `dataMemory` ports (synchronous write, combinational read), and produces the MEM/WB pipeline register consumed by writeback. It also:
- exposes the in-flight MEM and WB destinations to the ID-stage hazard unit;
- runs the halt-drain state machine;
- keeps load/store statistics counters.

---
 rtl/mem_stage_pkg.sv | 42 ++++
 rtl/mem_stage_if.sv | 58 +++++
 rtl/mem_stage_access_counter.sv | 19 +
 rtl/mem_stage.sv | 127 ++++++++++++
 tb/tb_mem_stage.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MIPS-lite memory-access stage.
package mem_stage_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int REG_W  = 5;

  // Low address bits that must be zero for a word access.
  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } haltState_t;

  // EX/MEM pipeline register contents.
  typedef struct packed {
    logic              valid;
    logic              memRead;
    logic              memWrite;
    logic              regWrite;
    logic              halt;
    logic [REG_W-1:0]  destReg;
    logic [DATA_W-1:0] aluResult;
    logic [DATA_W-1:0] storeData;
  } exMem_t;

  // MEM/WB pipeline register contents.
  typedef struct packed {
    logic              valid;
    logic              regWrite;
    logic              halt;
    logic [REG_W-1:0]  destReg;
    logic [DATA_W-1:0] data;
  } memWb_t;

  function automatic logic is_word_aligned(input logic [1:0] addr_low);
    return (addr_low & WORD_ALIGN_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Bundle of the EX-side inputs, dataMemory port and MEM/WB outputs of mem_stage.
// Handshake: exValid qualifies the EX payload in every cycle; the stage never
// applies back-pressure, so an instruction transfers on each posedge where
// exValid=1, flush=0 and the stage is running. wbValid qualifies the MEM/WB
// payload in the same way and writeback never stalls.
interface mem_stage_if #(
  parameter int DATAPATH_WIDTH = mem_stage_pkg::DATA_W,
  parameter int ADDRESS_WIDTH  = mem_stage_pkg::ADDR_W,
  parameter int REG_ADDR_WIDTH = mem_stage_pkg::REG_W
);
  logic                      exValid;
  logic [DATAPATH_WIDTH-1:0] exAluResult;
  logic [DATAPATH_WIDTH-1:0] exStoreData;
  logic [REG_ADDR_WIDTH-1:0] exDestReg;
  logic                      exMemRead;
  logic                      exMemWrite;
  logic                      exRegWrite;
  logic                      exHalt;
  logic                      flush;

  logic                      memWriteEnable;
  logic [ADDRESS_WIDTH-1:0]  memAddress;
  logic [DATAPATH_WIDTH-1:0] memDataIn;
  logic [DATAPATH_WIDTH-1:0] memDataOut;

  logic                      wbValid;
  logic                      wbRegWrite;
  logic [REG_ADDR_WIDTH-1:0] wbDestReg;
  logic [DATAPATH_WIDTH-1:0] wbData;
  logic [REG_ADDR_WIDTH-1:0] memBusyDest;
  logic                      memBusyValid;
  logic                      halted;
  logic                      misalignedAccess;
  logic [31:0]               loadCount;
  logic [31:0]               storeCount;

  // Pipeline / memory environment side.
  modport master (
    output exValid, exAluResult, exStoreData, exDestReg,
    output exMemRead, exMemWrite, exRegWrite, exHalt, flush,
    output memDataOut,
    input  memWriteEnable, memAddress, memDataIn,
    input  wbValid, wbRegWrite, wbDestReg, wbData,
    input  memBusyDest, memBusyValid, halted, misalignedAccess,
    input  loadCount, storeCount
  );

  // The memory stage itself.
  modport slave (
    input  exValid, exAluResult, exStoreData, exDestReg,
    input  exMemRead, exMemWrite, exRegWrite, exHalt, flush,
    input  memDataOut,
    output memWriteEnable, memAddress, memDataIn,
    output wbValid, wbRegWrite, wbDestReg, wbData,
    output memBusyDest, memBusyValid, halted, misalignedAccess,
    output loadCount, storeCount
  );
endinterface

// File: rtl/mem_stage_access_counter.sv
// Free-running wrapping event counter with an increment enable.
module access_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o
);
  logic [WIDTH-1:0] count_q;

  // Count one event per enabled cycle; wraps naturally at 2^WIDTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     count_q <= '0;
    else if (en_i) count_q <= count_q + 1'b1;
  end

  assign count_o = count_q;
endmodule

// File: rtl/mem_stage.sv
// MEM stage: EX/MEM register, dataMemory drive, MEM/WB register, halt drain
// state machine and load/store retirement counters.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATAPATH_WIDTH = DATA_W,
  parameter int ADDRESS_WIDTH  = ADDR_W,
  parameter int REG_ADDR_WIDTH = REG_W
) (
  input  logic        clk,
  input  logic        reset,
  mem_stage_if.slave  bus,
  output haltState_t  dbgState
);
  exMem_t     exmem_d, exmem_q;
  memWb_t     memwb_d, memwb_q;
  haltState_t state_q;
  logic       halted_q;
  logic       misaligned_q;
  logic       aligned;
  logic       load_ok;
  logic       store_ok;
  logic       misaligned_now;

  // EX/MEM next value: a bubble whenever flushed or no longer running.
  always_comb begin
    exmem_d = '0;
    if (!bus.flush && state_q == RUN) begin
      exmem_d.valid     = bus.exValid;
      exmem_d.memRead   = bus.exMemRead;
      exmem_d.memWrite  = bus.exMemWrite;
      exmem_d.regWrite  = bus.exRegWrite;
      exmem_d.halt      = bus.exHalt;
      exmem_d.destReg   = bus.exDestReg;
      exmem_d.aluResult = bus.exAluResult;
      exmem_d.storeData = bus.exStoreData;
    end
  end

  assign aligned        = is_word_aligned(exmem_q.aluResult[1:0]);
  assign load_ok        = exmem_q.valid & exmem_q.memRead & aligned;
  assign store_ok       = exmem_q.valid & exmem_q.memWrite & aligned;
  assign misaligned_now = exmem_q.valid & (exmem_q.memRead | exmem_q.memWrite) & ~aligned;

  // MEM/WB next value; a misaligned load returns zero instead of memory data.
  always_comb begin
    memwb_d          = '0;
    memwb_d.valid    = exmem_q.valid;
    memwb_d.regWrite = exmem_q.valid & exmem_q.regWrite;
    memwb_d.halt     = exmem_q.valid & exmem_q.halt;
    memwb_d.destReg  = exmem_q.destReg;
    if (exmem_q.memRead) memwb_d.data = aligned ? bus.memDataOut : '0;
    else                 memwb_d.data = exmem_q.aluResult;
  end

  // Pipeline registers advance every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  // Sticky misalignment flag, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               misaligned_q <= 1'b0;
    else if (misaligned_now) misaligned_q <= 1'b1;
  end

  // Halt drain: stop accepting work after HALT, finish once it leaves MEM/WB.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= RUN;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (bus.exValid && bus.exHalt && !bus.flush) state_q <= DRAIN;
        end
        DRAIN: begin
          if (memwb_q.valid && memwb_q.halt) begin
            state_q  <= HALTED;
            halted_q <= 1'b1;
          end
        end
        HALTED: begin
          state_q  <= HALTED;
          halted_q <= 1'b1;
        end
        default: begin
          state_q  <= RUN;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  access_counter #(.WIDTH(32)) u_load_cnt (
    .clk     (clk),
    .reset   (reset),
    .en_i    (load_ok),
    .count_o (bus.loadCount)
  );

  access_counter #(.WIDTH(32)) u_store_cnt (
    .clk     (clk),
    .reset   (reset),
    .en_i    (store_ok),
    .count_o (bus.storeCount)
  );

  assign bus.memWriteEnable   = store_ok;
  assign bus.memAddress       = ADDRESS_WIDTH'(exmem_q.aluResult);
  assign bus.memDataIn        = DATAPATH_WIDTH'(exmem_q.storeData);
  assign bus.wbValid          = memwb_q.valid;
  assign bus.wbRegWrite       = memwb_q.regWrite;
  assign bus.wbDestReg        = REG_ADDR_WIDTH'(memwb_q.destReg);
  assign bus.wbData           = DATAPATH_WIDTH'(memwb_q.data);
  assign bus.memBusyDest      = REG_ADDR_WIDTH'(exmem_q.destReg);
  assign bus.memBusyValid     = exmem_q.valid & exmem_q.regWrite;
  assign bus.halted           = halted_q;
  assign bus.misalignedAccess = misaligned_q;
  assign dbgState             = state_q;
endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed scenarios plus randomized instruction
// streams, checked by a scoreboard fed from a behavioural model.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int OP_ALU   = 0;
  localparam int OP_LOAD  = 1;
  localparam int OP_STORE = 2;
  localparam int OP_HALT  = 3;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       mem_init = 1'b0;
  int         cycle = 0;
  haltState_t dbg_state;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  mem_stage_if bus ();

  mem_stage dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .dbgState (dbg_state)
  );

  // ---------------- data memory environment ----------------
  logic [31:0] env_mem [0:63];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) env_mem[i] <= '0;
    end else if (bus.memWriteEnable) begin
      env_mem[bus.memAddress[7:2]] <= bus.memDataIn;
    end
  end

  assign bus.memDataOut = env_mem[bus.memAddress[7:2]];

  // ---------------- scoreboard state ----------------
  logic [37:0] exp_q[$];      // {regWrite, destReg, data}
  int          exp_cyc_q[$];
  logic [63:0] wr_q[$];       // {address, data}
  int          wr_cyc_q[$];
  int          n_checks = 0;
  int          n_pass = 0;

  // Behavioural model state
  logic [31:0] ref_mem [0:63];
  int          exp_loads;
  int          exp_stores;
  bit          exp_mis;
  bit          model_halted;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cycle);
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_cyc_q.delete();
    wr_q.delete();
    wr_cyc_q.delete();
    exp_loads    = 0;
    exp_stores   = 0;
    exp_mis      = 0;
    model_halted = 0;
  endtask

  // Instruction-level model: decides what each accepted instruction must
  // produce at writeback and on the memory write port.
  task automatic model_issue(input int op, input logic [31:0] a, input logic [31:0] d,
                             input logic [4:0] dst, input bit fl, input bit vld);
    logic [31:0] rdata;
    bit          word_ok;
    if (!vld || fl || model_halted) return;
    word_ok = (a % 4) == 0;
    rdata   = a;
    case (op)
      OP_LOAD: begin
        if (word_ok) begin
          rdata = ref_mem[(a / 4) % 64];
          exp_loads++;
        end else begin
          rdata   = 32'd0;
          exp_mis = 1;
        end
        exp_q.push_back({1'b1, dst, rdata});
      end
      OP_STORE: begin
        if (word_ok) begin
          ref_mem[(a / 4) % 64] = d;
          exp_stores++;
          wr_q.push_back({a, d});
          wr_cyc_q.push_back(cycle + 1);
        end else begin
          exp_mis = 1;
        end
        exp_q.push_back({1'b0, dst, a});
      end
      OP_HALT: begin
        model_halted = 1;
        exp_q.push_back({1'b0, dst, a});
      end
      default: exp_q.push_back({1'b1, dst, a});
    endcase
    exp_cyc_q.push_back(cycle + 2);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_bubble();
    bus.exValid     = 1'b0;
    bus.exAluResult = '0;
    bus.exStoreData = '0;
    bus.exDestReg   = '0;
    bus.exMemRead   = 1'b0;
    bus.exMemWrite  = 1'b0;
    bus.exRegWrite  = 1'b0;
    bus.exHalt      = 1'b0;
    bus.flush       = 1'b0;
  endtask

  task automatic issue(input int op, input logic [31:0] a, input logic [31:0] d,
                       input logic [4:0] dst, input bit fl, input bit vld);
    @(negedge clk);
    bus.exValid     = vld;
    bus.exAluResult = a;
    bus.exStoreData = d;
    bus.exDestReg   = dst;
    bus.exMemRead   = (op == OP_LOAD);
    bus.exMemWrite  = (op == OP_STORE);
    bus.exRegWrite  = (op == OP_ALU) || (op == OP_LOAD);
    bus.exHalt      = (op == OP_HALT);
    bus.flush       = fl;
    model_issue(op, a, d, dst, fl, vld);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      drive_bubble();
    end
  endtask

  // ---------------- monitor ----------------
  logic [37:0] mon_e;
  int          mon_c;
  logic [63:0] mon_w;

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.wbValid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL wb_unexpected: got dest %0d data %h, want no writeback (cycle %0d)",
                   bus.wbDestReg, bus.wbData, cycle);
        end else begin
          mon_e = exp_q.pop_front();
          mon_c = exp_cyc_q.pop_front();
          check("wb_cycle_rw_dest_data",
                96'({cycle, bus.wbRegWrite, bus.wbDestReg, bus.wbData}),
                96'({mon_c, mon_e}));
        end
      end
      if (bus.memWriteEnable) begin
        if (wr_q.size() == 0) begin
          n_checks++;
          $display("FAIL mem_write_unexpected: got addr %h data %h, want no write (cycle %0d)",
                   bus.memAddress, bus.memDataIn, cycle);
        end else begin
          mon_w = wr_q.pop_front();
          mon_c = wr_cyc_q.pop_front();
          check("mem_write_cycle_addr_data",
                96'({cycle, bus.memAddress, bus.memDataIn}),
                96'({mon_c, mon_w}));
        end
      end
    end
  end

  task automatic drain_check(input string name);
    int budget;
    budget = 50;
    while ((exp_q.size() != 0 || wr_q.size() != 0) && budget > 0) begin
      idle(1);
      budget--;
    end
    check(name, 96'(exp_q.size() + wr_q.size()), 96'd0);
  endtask

  // ---------------- stimulus ----------------
  int hc;

  initial begin
    drive_bubble();
    model_reset();
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    #1 reset = 1'b1;
    mem_init = 1'b1;
    repeat (2) @(posedge clk);
    mem_init = 1'b0;
    @(negedge clk);
    check("rst_wbValid", 96'(bus.wbValid), 96'd0);
    check("rst_wbRegWrite", 96'(bus.wbRegWrite), 96'd0);
    check("rst_memWriteEnable", 96'(bus.memWriteEnable), 96'd0);
    check("rst_memBusyValid", 96'(bus.memBusyValid), 96'd0);
    check("rst_halted", 96'(bus.halted), 96'd0);
    check("rst_misaligned", 96'(bus.misalignedAccess), 96'd0);
    check("rst_counts", 96'({bus.loadCount, bus.storeCount}), 96'd0);
    check("rst_wbData", 96'(bus.wbData), 96'd0);
    reset = 1'b0;

    // Stores then loads of the same words
    issue(OP_STORE, 32'h0, 32'h0000_0008, 5'd0, 0, 1);
    issue(OP_STORE, 32'h4, 32'h0000_1234, 5'd0, 0, 1);
    issue(OP_LOAD,  32'h0, 32'h0, 5'd1, 0, 1);
    issue(OP_LOAD,  32'h4, 32'h0, 5'd2, 0, 1);
    idle(4);
    check("store_count_2", 96'(bus.storeCount), 96'd2);
    check("load_count_2", 96'(bus.loadCount), 96'd2);

    // Plain ALU result; hazard outputs while it sits in EX/MEM
    issue(OP_ALU, 32'hDEAD_BEEF, 32'h0, 5'd5, 0, 1);
    idle(1);
    check("busy_valid_alu", 96'(bus.memBusyValid), 96'd1);
    check("busy_dest_alu", 96'(bus.memBusyDest), 96'd5);
    idle(3);

    // Store followed immediately by a load of the same word
    issue(OP_STORE, 32'h10, 32'hCAFE_F00D, 5'd0, 0, 1);
    issue(OP_LOAD,  32'h10, 32'h0, 5'd7, 0, 1);
    idle(3);

    // Misaligned store, then misaligned load
    issue(OP_STORE, 32'h6, 32'h0000_ABCD, 5'd0, 0, 1);
    idle(2);
    check("misaligned_set", 96'(bus.misalignedAccess), 96'd1);
    idle(3);
    check("misaligned_sticky", 96'(bus.misalignedAccess), 96'd1);
    check("store_count_after_misaligned", 96'(bus.storeCount), 96'd3);
    issue(OP_LOAD, 32'h9, 32'h0, 5'd3, 0, 1);
    idle(3);
    check("load_count_after_misaligned", 96'(bus.loadCount), 96'd3);

    // Flushed store
    issue(OP_STORE, 32'h8, 32'h0000_0055, 5'd0, 1, 1);
    idle(2);
    check("flush_wbValid", 96'(bus.wbValid), 96'd0);
    idle(2);
    check("flush_store_count", 96'(bus.storeCount), 96'd3);

    // Randomized stream (no HALT)
    for (int n = 0; n < 300; n++) begin
      int          op;
      logic [31:0] a;
      op = $urandom_range(0, 2);
      if (op == OP_ALU) begin
        a = $urandom;
      end else begin
        a = 32'($urandom_range(0, 255));
        if ($urandom_range(0, 4) != 0) a = a & ~32'h3;
      end
      issue(op, a, $urandom, 5'($urandom_range(0, 31)),
            $urandom_range(0, 9) == 0, $urandom_range(0, 9) != 0);
    end
    idle(3);
    drain_check("random_drain");
    check("random_load_count", 96'(bus.loadCount), 96'(exp_loads));
    check("random_store_count", 96'(bus.storeCount), 96'(exp_stores));
    check("random_misaligned", 96'(bus.misalignedAccess), 96'(exp_mis));

    // HALT then a store that must be ignored
    issue(OP_HALT, 32'h0, 32'h0, 5'd0, 0, 1);
    hc = cycle;
    issue(OP_STORE, 32'h20, 32'h0000_0077, 5'd0, 0, 1);
    idle(1);
    check("halt_not_yet", 96'(bus.halted), 96'd0);
    check("halt_state_drain", 96'(dbg_state), 96'(DRAIN));
    idle(1);
    check("halt_cycle_offset", 96'(cycle - hc), 96'd3);
    check("halted_set", 96'(bus.halted), 96'd1);
    issue(OP_LOAD, 32'h0, 32'h0, 5'd4, 0, 1);
    issue(OP_STORE, 32'h24, 32'h0000_0099, 5'd0, 0, 1);
    idle(4);
    check("halted_no_wb", 96'(bus.wbValid), 96'd0);
    check("halted_hold", 96'(bus.halted), 96'd1);
    drain_check("halt_drain");

    // Asynchronous reset mid-cycle clears halt, counters and flags
    @(posedge clk);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("mid_rst_halted", 96'(bus.halted), 96'd0);
    check("mid_rst_counts", 96'({bus.loadCount, bus.storeCount}), 96'd0);
    check("mid_rst_misaligned", 96'(bus.misalignedAccess), 96'd0);
    check("mid_rst_wbValid", 96'(bus.wbValid), 96'd0);
    @(negedge clk);
    reset = 1'b0;

    // Reset while a store is in EX/MEM drops the write enable immediately
    issue(OP_STORE, 32'h14, 32'h0000_0099, 5'd0, 0, 1);
    @(posedge clk);
    #2;
    check("store_we_before_reset", 96'(bus.memWriteEnable), 96'd1);
    reset = 1'b1;
    model_reset();
    #1;
    check("store_we_after_reset", 96'(bus.memWriteEnable), 96'd0);
    check("store_busy_after_reset", 96'(bus.memBusyValid), 96'd0);
    @(negedge clk);
    drive_bubble();
    reset = 1'b0;
    idle(3);
    drain_check("final_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
